// File: rtl/tone_meas.sv
// Rising-zero-crossing tone monitor: measures period (in valid samples) and
// half peak-to-peak amplitude per cycle, and tracks frequency lock and loss of signal.
module tone_meas #(
    parameter int W          = 16,
    parameter int PER_W      = 12,
    parameter int MAX_PERIOD = 4095,
    parameter int LOCK_CNT   = 4,
    parameter int TOL        = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                smpl_vld,
    input  logic signed [W-1:0] smpl,
    output logic [PER_W-1:0]    period,
    output logic [W-1:0]        ampl,
    output logic                meas_vld,
    output logic                locked,
    output logic                timeout,
    output logic [1:0]          dbg_state
);

    // smpl is consumed only in cycles where smpl_vld=1; there is no backpressure,
    // every valid sample is accepted and all state holds while smpl_vld=0.

    localparam int MC_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                prev_neg_q, prev_neg_d;
    logic [PER_W-1:0]    cnt_q, cnt_d;
    logic [MC_W-1:0]     match_q, match_d;
    logic                has_prev_q, has_prev_d;
    logic signed [W-1:0] max_q, max_d;
    logic signed [W-1:0] min_q, min_d;
    logic [PER_W-1:0]    period_q, period_d;
    logic [W-1:0]        ampl_q, ampl_d;
    logic                meas_vld_q, meas_vld_d;
    logic                timeout_q, timeout_d;

    logic                crossing;
    logic [W:0]          span;
    logic [PER_W-1:0]    diff;
    logic                in_tol;
    logic                cnt_at_max;
    logic [MC_W-1:0]     match_inc;

    assign crossing   = smpl_vld && !smpl[W-1] && prev_neg_q;
    // max >= min inside a window, so the modular W+1-bit difference is exact
    assign span       = {max_q[W-1], max_q} - {min_q[W-1], min_q};
    assign diff       = (cnt_q >= period_q) ? (cnt_q - period_q) : (period_q - cnt_q);
    assign in_tol     = has_prev_q && (diff <= PER_W'(TOL));
    assign cnt_at_max = (cnt_q == PER_W'(MAX_PERIOD));
    assign match_inc  = (match_q == MC_W'(LOCK_CNT)) ? match_q : (match_q + MC_W'(1));

    always_comb begin
        state_d    = state_q;
        prev_neg_d = prev_neg_q;
        cnt_d      = cnt_q;
        match_d    = match_q;
        has_prev_d = has_prev_q;
        max_d      = max_q;
        min_d      = min_q;
        period_d   = period_q;
        ampl_d     = ampl_q;
        meas_vld_d = 1'b0;
        timeout_d  = 1'b0;

        if (smpl_vld) begin
            prev_neg_d = smpl[W-1];
            unique case (state_q)
                IDLE: begin
                    if (crossing) begin
                        state_d    = TRACK;
                        cnt_d      = PER_W'(1);
                        max_d      = smpl;
                        min_d      = smpl;
                        match_d    = '0;
                        has_prev_d = 1'b0;
                    end
                end
                TRACK, LOCKED: begin
                    if (crossing) begin
                        meas_vld_d = 1'b1;
                        period_d   = cnt_q;
                        ampl_d     = span[W:1];
                        has_prev_d = 1'b1;
                        cnt_d      = PER_W'(1);
                        max_d      = smpl;
                        min_d      = smpl;
                        if (in_tol) begin
                            match_d = match_inc;
                            if (match_inc == MC_W'(LOCK_CNT)) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            match_d = '0;
                            state_d = TRACK;
                        end
                    end else if (cnt_at_max) begin
                        timeout_d  = 1'b1;
                        state_d    = IDLE;
                        cnt_d      = '0;
                        match_d    = '0;
                        has_prev_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + PER_W'(1);
                        if (smpl > max_q) max_d = smpl;
                        if (smpl < min_q) min_d = smpl;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_neg_q <= 1'b0;
            cnt_q      <= '0;
            match_q    <= '0;
            has_prev_q <= 1'b0;
            max_q      <= '0;
            min_q      <= '0;
            period_q   <= '0;
            ampl_q     <= '0;
            meas_vld_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_neg_q <= prev_neg_d;
            cnt_q      <= cnt_d;
            match_q    <= match_d;
            has_prev_q <= has_prev_d;
            max_q      <= max_d;
            min_q      <= min_d;
            period_q   <= period_d;
            ampl_q     <= ampl_d;
            meas_vld_q <= meas_vld_d;
            timeout_q  <= timeout_d;
        end
    end

    assign period    = period_q;
    assign ampl      = ampl_q;
    assign meas_vld  = meas_vld_q;
    assign timeout   = timeout_q;
    assign locked    = (state_q == LOCKED);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tone_meas.sv
// Directed bench for tone_meas: sine, sparse-valid, frequency step, timeout,
// full-scale square and mid-window reset, with hand-computed expectations.
module tb_tone_meas;

    localparam int W     = 16;
    localparam int PER_W = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic                smpl_vld;
    logic signed [W-1:0] smpl;
    logic [PER_W-1:0]    period;
    logic [W-1:0]        ampl;
    logic                meas_vld;
    logic                locked;
    logic                timeout;
    logic [1:0]          dbg_state;

    int n_chk     = 0;
    int n_err     = 0;
    int meas_seen = 0;
    int to_seen   = 0;

    int sine30 [30] = '{0, 16, 31, 45, 58, 68, 74, 77, 77, 74, 68, 58, 45, 31, 16,
                        -16, -31, -45, -58, -68, -74, -77, -77, -77, -74, -68, -58, -45, -31, -16};

    tone_meas dut (
        .clk       (clk),
        .rst       (rst),
        .smpl_vld  (smpl_vld),
        .smpl      (smpl),
        .period    (period),
        .ampl      (ampl),
        .meas_vld  (meas_vld),
        .locked    (locked),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // pulse counters sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (meas_vld) meas_seen++;
        if (timeout)  to_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        smpl_vld = 1'b0;
        smpl     = '0;
        @(posedge clk); #1;
        rst      = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_period"}, 32'(period), 0);
        check({tag, "_ampl"}, 32'(ampl), 0);
        check({tag, "_meas_vld"}, 32'(meas_vld), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    task automatic put(input int v);
        smpl     = W'(v);
        smpl_vld = 1'b1;
        @(posedge clk); #1;
        smpl_vld = 1'b0;
        smpl     = W'($urandom_range(0, 65535));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_meas(input string tag, input int per, input int amp, input logic lk);
        check({tag, "_meas_vld"}, 32'(meas_vld), 1);
        check({tag, "_period"}, 32'(period), 32'(per));
        check({tag, "_ampl"}, 32'(ampl), 32'(amp));
        check({tag, "_locked"}, 32'(locked), 32'(lk));
    endtask

    // Fresh after reset: first 0 is not a crossing, crossing k+1 yields measurement k.
    task automatic run_sine(input string tag, input int periods, input int gap);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < 30; i++) begin
                put(sine30[i]);
                if (i == 0) begin
                    if (p >= 2) check_meas(tag, 30, 77, (p - 1) >= 5);
                    else        check({tag, "_no_meas"}, 32'(meas_vld), 0);
                end
                idle(gap);
            end
        end
    endtask

    function automatic int wave40(input int i);
        if (i == 0)      return 0;
        else if (i < 20) return 77;
        else             return -77;
    endfunction

    initial begin
        int m0;
        int t0;
        int k;
        int found;

        // continuous sine
        do_reset();
        check_reset("rst1");
        check("rst1_state", 32'(dbg_state), 0);
        m0 = meas_seen; t0 = to_seen;
        run_sine("s1", 7, 0);
        check("s1_meas_count", 32'(meas_seen - m0), 5);
        check("s1_timeouts", 32'(to_seen - t0), 0);

        // valid every third cycle
        do_reset();
        check_reset("rst2");
        m0 = meas_seen; t0 = to_seen;
        run_sine("s2", 7, 2);
        check("s2_meas_count", 32'(meas_seen - m0), 5);
        check("s2_timeouts", 32'(to_seen - t0), 0);

        // locked 30-sample tone stepped to 40 samples
        do_reset();
        run_sine("s3a", 7, 0);
        m0 = meas_seen;
        for (int q = 0; q < 6; q++) begin
            for (int i = 0; i < 40; i++) begin
                put(wave40(i));
                if (i == 0) begin
                    if (q == 0) check_meas("s3_last30", 30, 77, 1'b1);
                    else        check_meas("s3_p40", 40, 77, q == 5);
                end
            end
        end
        check("s3_meas_count", 32'(meas_seen - m0), 6);

        // locked tone then constant zero: one timeout after MAX_PERIOD samples
        do_reset();
        run_sine("s4a", 7, 0);
        t0 = to_seen; m0 = meas_seen;
        put(0);
        check_meas("s4_final", 30, 77, 1'b1);
        k = 1;
        found = 0;
        while (k < 5000 && found == 0) begin
            put(0);
            k++;
            if (timeout) found = k;
        end
        check("s4_timeout_at_sample", 32'(found), 4096);
        check("s4_locked_after_to", 32'(locked), 0);
        check("s4_period_hold", 32'(period), 30);
        check("s4_ampl_hold", 32'(ampl), 77);
        repeat (50) put(0);
        check("s4_timeout_count", 32'(to_seen - t0), 1);
        check("s4_meas_count", 32'(meas_seen - m0), 1);
        check("s4_state_idle", 32'(dbg_state), 0);

        // full-scale square wave
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) begin
                put((i < 8) ? -32768 : 32767);
                if (i == 8) begin
                    if (p >= 1) check_meas("s5_sq", 16, 32767, 1'b0);
                    else        check("s5_no_meas", 32'(meas_vld), 0);
                end
            end
        end

        // reset mid-window while tracking, with prev sample negative
        do_reset();
        run_sine("s6a", 2, 0);
        for (int i = 0; i < 20; i++) begin
            put(sine30[i]);
            if (i == 0) check_meas("s6_pre", 30, 77, 1'b0);
        end
        do_reset();
        check_reset("s6_rst");
        check("s6_rst_state", 32'(dbg_state), 0);
        m0 = meas_seen;
        run_sine("s6b", 3, 0);
        check("s6_meas_count", 32'(meas_seen - m0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
